// File: rtl/mult_pkg.sv
// Constants shared by the multiplier datapath and its control FSM.
package mult_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_WR   = 2'b11
  } mode_e;

  function automatic logic is_shift(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/step_counter.sv
// Counts qualifying shift steps of one sequence and flags its completion.
module step_counter #(
  parameter int STEPS = 32,
  parameter int CNT_W = $clog2(STEPS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(STEPS - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
      busy_d  = 1'b1;
    end else if (inc_i && busy_q) begin
      count_d = count_q + 1'b1;
      // The step that reaches STEPS ends the sequence; Count then parks there.
      if (count_q == LAST_C) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/shift_register_preset.sv
// Multi-mode datapath register: preset load, shifts with serial I/O, parallel
// write, plus a step counter that tells the multiplier FSM when a sequence ends.
module shift_register_preset
  import mult_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEPS = 32,
  parameter int CNT_W = $clog2(STEPS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic             SerIn,
  input  logic [WIDTH-1:0] Preset,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Out,
  output logic             SerOut,
  output logic [CNT_W-1:0] Count,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic             shift_step;

  always_comb begin
    data_d = data_q;
    ser_d  = ser_q;
    if (Load) begin
      data_d = Preset;
      ser_d  = 1'b0;
    end else if (En) begin
      case (mode_e'(Mode))
        MODE_SHR: begin
          data_d = {SerIn, data_q[WIDTH-1:1]};
          ser_d  = data_q[0];
        end
        MODE_SHL: begin
          data_d = {data_q[WIDTH-2:0], SerIn};
          ser_d  = data_q[WIDTH-1];
        end
        MODE_WR:  data_d = In;
        default:  ;
      endcase
    end
  end

  assign shift_step = !Load && En && is_shift(Mode);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_q <= '0;
      ser_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      ser_q  <= ser_d;
    end
  end

  step_counter #(
    .STEPS (STEPS),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .clr_i   (Load),
    .inc_i   (shift_step),
    .count_o (Count),
    .busy_o  (Busy),
    .done_o  (Done)
  );

  assign Out    = data_q;
  assign SerOut = ser_q;

endmodule

// File: tb/tb_shift_register_preset.sv
// Randomised and directed checks of two register instances (64/32 and 8/3)
// against a behavioural model of the load/shift/write/count rules.
module tb_shift_register_preset;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, load_a, en_a, ser_in_a;
  logic [1:0]  mode_a;
  logic [63:0] preset_a, in_a, out_a;
  logic        ser_out_a, busy_a, done_a;
  logic [5:0]  count_a;

  logic        rst_b, load_b, en_b, ser_in_b;
  logic [1:0]  mode_b;
  logic [7:0]  preset_b, in_b, out_b;
  logic        ser_out_b, busy_b, done_b;
  logic [1:0]  count_b;

  shift_register_preset #(.WIDTH(64), .STEPS(32)) dut_a (
    .Clk(clk), .Reset(rst_a), .Load(load_a), .En(en_a), .Mode(mode_a),
    .SerIn(ser_in_a), .Preset(preset_a), .In(in_a), .Out(out_a),
    .SerOut(ser_out_a), .Count(count_a), .Busy(busy_a), .Done(done_a)
  );

  shift_register_preset #(.WIDTH(8), .STEPS(3)) dut_b (
    .Clk(clk), .Reset(rst_b), .Load(load_b), .En(en_b), .Mode(mode_b),
    .SerIn(ser_in_b), .Preset(preset_b), .In(in_b), .Out(out_b),
    .SerOut(ser_out_b), .Count(count_b), .Busy(busy_b), .Done(done_b)
  );

  // Behavioural model, index 0 = 64-bit instance, 1 = 8-bit instance
  logic [63:0] m_out  [2];
  logic        m_ser  [2];
  int          m_cnt  [2];
  logic        m_busy [2];
  logic        m_done [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 64 : 8;
  endfunction

  function automatic int steps_of(input int k);
    return (k == 0) ? 32 : 3;
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    logic [63:0] one = 64'd1;
    return (k == 0) ? '1 : ((one << width_of(k)) - 1);
  endfunction

  task automatic model_reset(input int k);
    m_out[k] = '0; m_ser[k] = 1'b0; m_cnt[k] = 0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
  endtask

  task automatic model_update(input int k, input logic load, input logic en, input logic [1:0] mode,
                              input logic serin, input logic [63:0] preset, input logic [63:0] in);
    int w = width_of(k);
    logic [63:0] v = m_out[k];
    logic [63:0] sbit = {63'd0, serin};
    bit shifted = 0;
    m_done[k] = 1'b0;
    if (load) begin
      m_out[k] = preset & mask_of(k);
      m_ser[k] = 1'b0; m_cnt[k] = 0; m_busy[k] = 1'b1;
    end else if (en) begin
      if (mode == 2'd1) begin
        m_ser[k] = v[0];
        m_out[k] = (v >> 1) | (sbit << (w - 1));
        shifted = 1;
      end else if (mode == 2'd2) begin
        m_ser[k] = v[w-1];
        m_out[k] = ((v << 1) | sbit) & mask_of(k);
        shifted = 1;
      end else if (mode == 2'd3) begin
        m_out[k] = in & mask_of(k);
      end
      if (shifted && m_busy[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == steps_of(k)) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input int k);
    string p = (k == 0) ? "a" : "b";
    if (k == 0) begin
      check_val({p, ".out"},    out_a,           m_out[0]);
      check_val({p, ".serout"}, 64'(ser_out_a),  64'(m_ser[0]));
      check_val({p, ".count"},  64'(count_a),    64'(m_cnt[0]));
      check_val({p, ".busy"},   64'(busy_a),     64'(m_busy[0]));
      check_val({p, ".done"},   64'(done_a),     64'(m_done[0]));
    end else begin
      check_val({p, ".out"},    64'(out_b),      m_out[1]);
      check_val({p, ".serout"}, 64'(ser_out_b),  64'(m_ser[1]));
      check_val({p, ".count"},  64'(count_b),    64'(m_cnt[1]));
      check_val({p, ".busy"},   64'(busy_b),     64'(m_busy[1]));
      check_val({p, ".done"},   64'(done_b),     64'(m_done[1]));
    end
  endtask

  task automatic run_cycle(input int k, input logic load, input logic en, input logic [1:0] mode,
                           input logic serin, input logic [63:0] preset, input logic [63:0] in);
    if (k == 0) begin
      load_a = load; en_a = en; mode_a = mode; ser_in_a = serin; preset_a = preset; in_a = in;
    end else begin
      load_b = load; en_b = en; mode_b = mode; ser_in_b = serin; preset_b = preset[7:0]; in_b = in[7:0];
    end
    @(posedge clk);
    model_update(k, load, en, mode, serin, preset, in);
    #1;
    compare_all(k);
    if (k == 0) begin load_a = 1'b0; en_a = 1'b0; end
    else begin load_b = 1'b0; en_b = 1'b0; end
  endtask

  task automatic shifts(input int k, input int n, input logic [1:0] mode, input logic serin);
    for (int i = 0; i < n; i++) run_cycle(k, 1'b0, 1'b1, mode, serin, '0, '0);
  endtask

  task automatic random_cycles(input int k, input int n);
    for (int i = 0; i < n; i++)
      run_cycle(k, ($urandom_range(15) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
                1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    rst_a = 1'b0; load_a = 1'b1; en_a = 1'b0; mode_a = 2'd0; ser_in_a = 1'b0;
    preset_a = 64'h1234567887654321; in_a = '0;
    rst_b = 1'b0; load_b = 1'b0; en_b = 1'b0; mode_b = 2'd0; ser_in_b = 1'b0;
    preset_b = '0; in_b = '0;
    model_reset(0); model_reset(1);
    #2;
    compare_all(0);
    @(posedge clk); #1;
    compare_all(0);
    rst_a = 1'b1; load_a = 1'b0;
    run_cycle(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);

    run_cycle(0, 1'b1, 1'b0, 2'd0, 1'b0, 64'h1234567887654321, '0);
    shifts(0, 32, 2'd1, 1'b0);
    check_val("a.shr32_out", out_a, 64'h0000000012345678);
    check_val("a.shr32_done", 64'(done_a), 64'd1);
    run_cycle(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    check_val("a.done_pulse_end", 64'(done_a), 64'd0);

    run_cycle(0, 1'b1, 1'b1, 2'd2, 1'b1, 64'h8000000000000001, '0);
    shifts(0, 1, 2'd2, 1'b1);
    check_val("a.shl_out", out_a, 64'h0000000000000003);
    check_val("a.shl_serout", 64'(ser_out_a), 64'd1);
    shifts(0, 4, 2'd2, 1'b0);
    run_cycle(0, 1'b0, 1'b1, 2'd3, 1'b0, '0, 64'hDEADBEEF00000000);
    check_val("a.wr_out", out_a, 64'hDEADBEEF00000000);
    check_val("a.wr_count", 64'(count_a), 64'd5);
    shifts(0, 27, 2'd1, 1'b1);
    check_val("a.after_wr_done", 64'(done_a), 64'd1);

    run_cycle(0, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0F0F0F0F0F0F0F0F, '0);
    shifts(0, 20, 2'd1, 1'b0);
    run_cycle(0, 1'b1, 1'b1, 2'd1, 1'b0, 64'hCAFEF00D12345678, '0);
    check_val("a.reload_out", out_a, 64'hCAFEF00D12345678);
    shifts(0, 31, 2'd2, 1'b0);
    check_val("a.reload_no_done", 64'(done_a), 64'd0);
    shifts(0, 1, 2'd2, 1'b0);
    check_val("a.reload_done", 64'(done_a), 64'd1);

    random_cycles(0, 1500);

    rst_b = 1'b1;
    run_cycle(1, 1'b1, 1'b0, 2'd0, 1'b0, 64'hA5, '0);
    shifts(1, 3, 2'd1, 1'b0);
    check_val("b.shr3_out", 64'(out_b), 64'h14);
    // Third shift drops bit 0 of 8'h29, which is 1
    check_val("b.shr3_serout", 64'(ser_out_b), 64'd1);
    check_val("b.shr3_done", 64'(done_b), 64'd1);

    run_cycle(1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h3C, '0);
    shifts(1, 1, 2'd2, 1'b1);
    @(negedge clk);
    rst_b = 1'b0;
    model_reset(1);
    #1;
    compare_all(1);
    @(posedge clk); #1;
    compare_all(1);
    rst_b = 1'b1;
    shifts(1, 3, 2'd1, 1'b1);
    check_val("b.post_reset_no_done", 64'(done_b), 64'd0);

    random_cycles(1, 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
